// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side instruction/control bundle, EX-side registered copy, and hazard/flush/hold handshake.
`default_nettype none

interface id_ex_stage_if;
    logic        ID_valid;
    logic [31:0] ID_pc;
    logic [31:0] ID_rs1Data;
    logic [31:0] ID_rs2Data;
    logic [31:0] ID_imm;
    logic [4:0]  ID_rs1Addr;
    logic [4:0]  ID_rs2Addr;
    logic [4:0]  ID_rdAddr;
    logic        ID_usesRs1;
    logic        ID_usesRs2;
    logic        ID_reg_W_En;
    logic        ID_memRead;
    logic        ID_memWrite;
    logic [3:0]  ID_aluOp;
    logic        ID_aluSrc;
    logic [1:0]  ID_wbSel;
    logic        ID_branch;
    logic        ID_jump;
    logic        flush;
    logic        hold;

    logic        EX_valid;
    logic [31:0] EX_pc;
    logic [31:0] EX_rs1Data;
    logic [31:0] EX_rs2Data;
    logic [31:0] EX_imm;
    logic [4:0]  EX_rs1Addr;
    logic [4:0]  EX_rs2Addr;
    logic [4:0]  EX_rdAddr;
    logic        EX_reg_W_En;
    logic        EX_memRead;
    logic        EX_memWrite;
    logic [3:0]  EX_aluOp;
    logic        EX_aluSrc;
    logic [1:0]  EX_wbSel;
    logic        EX_branch;
    logic        EX_jump;
    logic        stall;

    modport master (
        output ID_valid, ID_pc, ID_rs1Data, ID_rs2Data, ID_imm,
        output ID_rs1Addr, ID_rs2Addr, ID_rdAddr, ID_usesRs1, ID_usesRs2,
        output ID_reg_W_En, ID_memRead, ID_memWrite, ID_aluOp, ID_aluSrc,
        output ID_wbSel, ID_branch, ID_jump, flush, hold,
        input  EX_valid, EX_pc, EX_rs1Data, EX_rs2Data, EX_imm,
        input  EX_rs1Addr, EX_rs2Addr, EX_rdAddr, EX_reg_W_En, EX_memRead,
        input  EX_memWrite, EX_aluOp, EX_aluSrc, EX_wbSel, EX_branch, EX_jump,
        input  stall
    );

    modport slave (
        input  ID_valid, ID_pc, ID_rs1Data, ID_rs2Data, ID_imm,
        input  ID_rs1Addr, ID_rs2Addr, ID_rdAddr, ID_usesRs1, ID_usesRs2,
        input  ID_reg_W_En, ID_memRead, ID_memWrite, ID_aluOp, ID_aluSrc,
        input  ID_wbSel, ID_branch, ID_jump, flush, hold,
        output EX_valid, EX_pc, EX_rs1Data, EX_rs2Data, EX_imm,
        output EX_rs1Addr, EX_rs2Addr, EX_rdAddr, EX_reg_W_En, EX_memRead,
        output EX_memWrite, EX_aluOp, EX_aluSrc, EX_wbSel, EX_branch, EX_jump,
        output stall
    );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush/hold control.
// Optional macro ID_EX_BUBBLE_COUNT_EN adds a 32-bit bubble performance counter.
`default_nettype none

module id_ex_stage (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
`ifdef ID_EX_BUBBLE_COUNT_EN
    ,
    output logic [31:0]   bubble_count
`endif
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1Data;
        logic [31:0] rs2Data;
        logic [31:0] imm;
        logic [4:0]  rs1Addr;
        logic [4:0]  rs2Addr;
        logic [4:0]  rdAddr;
        logic        reg_W_En;
        logic        memRead;
        logic        memWrite;
        logic [3:0]  aluOp;
        logic        aluSrc;
        logic [1:0]  wbSel;
        logic        branch;
        logic        jump;
    } ex_t;

    ex_t  r_ex;
    ex_t  w_ex_next;
    logic w_hazard;
    logic w_bubble;

    // Load in EX whose destination feeds a live source operand of the ID instruction.
    assign w_hazard = r_ex.valid & r_ex.memRead & (r_ex.rdAddr != 5'd0) & bus.ID_valid &
                      ((bus.ID_usesRs1 & (bus.ID_rs1Addr == r_ex.rdAddr)) |
                       (bus.ID_usesRs2 & (bus.ID_rs2Addr == r_ex.rdAddr)));

    assign bus.stall = w_hazard & ~bus.flush;
    assign w_bubble  = bus.flush | (~bus.hold & w_hazard);

    always_comb begin
        w_ex_next = r_ex;
        if (w_bubble) begin
            w_ex_next = '0;
        end else if (!bus.hold) begin
            w_ex_next.valid    = bus.ID_valid;
            w_ex_next.pc       = bus.ID_pc;
            w_ex_next.rs1Data  = bus.ID_rs1Data;
            w_ex_next.rs2Data  = bus.ID_rs2Data;
            w_ex_next.imm      = bus.ID_imm;
            w_ex_next.rs1Addr  = bus.ID_rs1Addr;
            w_ex_next.rs2Addr  = bus.ID_rs2Addr;
            w_ex_next.rdAddr   = bus.ID_rdAddr;
            w_ex_next.reg_W_En = bus.ID_valid & bus.ID_reg_W_En & (bus.ID_rdAddr != 5'd0);
            w_ex_next.memRead  = bus.ID_valid & bus.ID_memRead;
            w_ex_next.memWrite = bus.ID_valid & bus.ID_memWrite;
            w_ex_next.aluOp    = bus.ID_aluOp;
            w_ex_next.aluSrc   = bus.ID_aluSrc;
            w_ex_next.wbSel    = bus.ID_wbSel;
            w_ex_next.branch   = bus.ID_valid & bus.ID_branch;
            w_ex_next.jump     = bus.ID_valid & bus.ID_jump;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_ex_next;
        end
    end

    assign bus.EX_valid    = r_ex.valid;
    assign bus.EX_pc       = r_ex.pc;
    assign bus.EX_rs1Data  = r_ex.rs1Data;
    assign bus.EX_rs2Data  = r_ex.rs2Data;
    assign bus.EX_imm      = r_ex.imm;
    assign bus.EX_rs1Addr  = r_ex.rs1Addr;
    assign bus.EX_rs2Addr  = r_ex.rs2Addr;
    assign bus.EX_rdAddr   = r_ex.rdAddr;
    assign bus.EX_reg_W_En = r_ex.reg_W_En;
    assign bus.EX_memRead  = r_ex.memRead;
    assign bus.EX_memWrite = r_ex.memWrite;
    assign bus.EX_aluOp    = r_ex.aluOp;
    assign bus.EX_aluSrc   = r_ex.aluSrc;
    assign bus.EX_wbSel    = r_ex.wbSel;
    assign bus.EX_branch   = r_ex.branch;
    assign bus.EX_jump     = r_ex.jump;

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] r_bubble_count;

    // Counts only edges that actually insert a bubble, so a frozen hazard is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_count <= 32'd0;
        end else if (w_bubble) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign bubble_count = r_bubble_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table, reset/wrap sequences and randomized model comparison for id_ex_stage.
`default_nettype none

module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1Data;
        logic [31:0] rs2Data;
        logic [31:0] imm;
        logic [4:0]  rs1Addr;
        logic [4:0]  rs2Addr;
        logic [4:0]  rdAddr;
        logic        reg_W_En;
        logic        memRead;
        logic        memWrite;
        logic [3:0]  aluOp;
        logic        aluSrc;
        logic [1:0]  wbSel;
        logic        branch;
        logic        jump;
    } rec_t;

    typedef struct {
        rec_t id;
        logic usesRs1;
        logic usesRs2;
        logic flush;
        logic hold;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [4:0]  e_rd;
        logic        e_mr;
        logic        e_we;
        logic [31:0] e_bc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bc_w;
    int          checks = 0;
    int          errors = 0;
    rec_t        mex;
    logic [31:0] mbc;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ID_EX_BUBBLE_COUNT_EN
        ,
        .bubble_count (bc_w)
`endif
    );

`ifndef ID_EX_BUBBLE_COUNT_EN
    assign bc_w = 32'd0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input stim_t s);
        bus.ID_valid    = s.id.valid;
        bus.ID_pc       = s.id.pc;
        bus.ID_rs1Data  = s.id.rs1Data;
        bus.ID_rs2Data  = s.id.rs2Data;
        bus.ID_imm      = s.id.imm;
        bus.ID_rs1Addr  = s.id.rs1Addr;
        bus.ID_rs2Addr  = s.id.rs2Addr;
        bus.ID_rdAddr   = s.id.rdAddr;
        bus.ID_reg_W_En = s.id.reg_W_En;
        bus.ID_memRead  = s.id.memRead;
        bus.ID_memWrite = s.id.memWrite;
        bus.ID_aluOp    = s.id.aluOp;
        bus.ID_aluSrc   = s.id.aluSrc;
        bus.ID_wbSel    = s.id.wbSel;
        bus.ID_branch   = s.id.branch;
        bus.ID_jump     = s.id.jump;
        bus.ID_usesRs1  = s.usesRs1;
        bus.ID_usesRs2  = s.usesRs2;
        bus.flush       = s.flush;
        bus.hold        = s.hold;
    endtask

    function automatic rec_t read_ex();
        rec_t r;
        r.valid    = bus.EX_valid;
        r.pc       = bus.EX_pc;
        r.rs1Data  = bus.EX_rs1Data;
        r.rs2Data  = bus.EX_rs2Data;
        r.imm      = bus.EX_imm;
        r.rs1Addr  = bus.EX_rs1Addr;
        r.rs2Addr  = bus.EX_rs2Addr;
        r.rdAddr   = bus.EX_rdAddr;
        r.reg_W_En = bus.EX_reg_W_En;
        r.memRead  = bus.EX_memRead;
        r.memWrite = bus.EX_memWrite;
        r.aluOp    = bus.EX_aluOp;
        r.aluSrc   = bus.EX_aluSrc;
        r.wbSel    = bus.EX_wbSel;
        r.branch   = bus.EX_branch;
        r.jump     = bus.EX_jump;
        return r;
    endfunction

    function automatic stim_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                                 input logic u2, input logic we, input logic mr,
                                 input logic fl, input logic ho);
        stim_t s;
        s.id         = '0;
        s.id.valid   = v;
        s.id.pc      = pc;
        s.id.rs1Data = pc + 32'd1;
        s.id.rs2Data = pc + 32'd2;
        s.id.imm     = pc + 32'd3;
        s.id.rs1Addr = rs1;
        s.id.rs2Addr = rs2;
        s.id.rdAddr  = rd;
        s.id.reg_W_En = we;
        s.id.memRead = mr;
        s.id.wbSel   = {1'b0, mr};
        s.usesRs1    = u1;
        s.usesRs2    = u2;
        s.flush      = fl;
        s.hold       = ho;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic st, input logic v, input logic [31:0] pc,
                                 input logic [4:0] rd, input logic mr, input logic we,
                                 input logic [31:0] bc);
        vec_t r;
        r.s = s; r.e_stall = st; r.e_valid = v; r.e_pc = pc;
        r.e_rd = rd; r.e_mr = mr; r.e_we = we; r.e_bc = bc;
        return r;
    endfunction

    // Reference: a load in EX blocks any ID instruction that reads its destination (x0 never blocks).
    function automatic logic model_hazard(input rec_t ex, input stim_t s);
        if (!(ex.valid && ex.memRead) || ex.rdAddr == 5'd0 || !s.id.valid) return 1'b0;
        return (s.usesRs1 && s.id.rs1Addr == ex.rdAddr) || (s.usesRs2 && s.id.rs2Addr == ex.rdAddr);
    endfunction

    function automatic rec_t model_next(input rec_t ex, input stim_t s, output logic bubble);
        rec_t n;
        bubble = s.flush || (!s.hold && model_hazard(ex, s));
        if (bubble) return '0;
        if (s.hold) return ex;
        n = s.id;
        if (!n.valid) begin
            n.reg_W_En = 1'b0; n.memRead = 1'b0; n.memWrite = 1'b0;
            n.branch = 1'b0;   n.jump = 1'b0;
        end
        if (n.rdAddr == 5'd0) n.reg_W_En = 1'b0;
        return n;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.id.valid    = ($urandom_range(0, 3) != 0);
        s.id.pc       = $urandom;
        s.id.rs1Data  = $urandom;
        s.id.rs2Data  = $urandom;
        s.id.imm      = $urandom;
        s.id.rs1Addr  = 5'($urandom_range(0, 3));
        s.id.rs2Addr  = 5'($urandom_range(0, 3));
        s.id.rdAddr   = 5'($urandom_range(0, 3));
        s.id.reg_W_En = 1'($urandom);
        s.id.memRead  = ($urandom_range(0, 2) == 0);
        s.id.memWrite = 1'($urandom);
        s.id.aluOp    = 4'($urandom);
        s.id.aluSrc   = 1'($urandom);
        s.id.wbSel    = 2'($urandom);
        s.id.branch   = 1'($urandom);
        s.id.jump     = 1'($urandom);
        s.usesRs1     = 1'($urandom);
        s.usesRs2     = 1'($urandom);
        s.flush       = ($urandom_range(0, 7) == 0);
        s.hold        = ($urandom_range(0, 4) == 0);
        return s;
    endfunction

    vec_t tbl[19];

    initial begin
        stim_t idle;
        stim_t rs;
        logic  bub;
        logic  m_stall;

        tbl[0]  = mkv(mk(1, 32'h10, 1, 0, 5, 1, 0, 1, 1, 0, 0), 0, 1, 32'h10, 5, 1, 1, 0);
        tbl[1]  = mkv(mk(1, 32'h14, 5, 7, 6, 1, 1, 1, 0, 0, 0), 1, 0, 32'h00, 0, 0, 0, 1);
        tbl[2]  = mkv(mk(1, 32'h14, 5, 7, 6, 1, 1, 1, 0, 0, 0), 0, 1, 32'h14, 6, 0, 1, 1);
        tbl[3]  = mkv(mk(1, 32'h18, 1, 0, 0, 1, 0, 1, 1, 0, 0), 0, 1, 32'h18, 0, 1, 0, 1);
        tbl[4]  = mkv(mk(1, 32'h1c, 0, 0, 7, 1, 1, 1, 0, 0, 0), 0, 1, 32'h1c, 7, 0, 1, 1);
        tbl[5]  = mkv(mk(1, 32'h20, 1, 0, 5, 1, 0, 1, 1, 0, 0), 0, 1, 32'h20, 5, 1, 1, 1);
        tbl[6]  = mkv(mk(1, 32'h24, 3, 5, 8, 1, 0, 1, 0, 0, 0), 0, 1, 32'h24, 8, 0, 1, 1);
        tbl[7]  = mkv(mk(1, 32'h28, 1, 0, 5, 1, 0, 1, 1, 0, 0), 0, 1, 32'h28, 5, 1, 1, 1);
        tbl[8]  = mkv(mk(1, 32'h2c, 5, 0, 9, 1, 0, 1, 0, 1, 0), 0, 0, 32'h00, 0, 0, 0, 2);
        tbl[9]  = mkv(mk(1, 32'h40, 1, 2, 3, 1, 1, 1, 0, 0, 0), 0, 1, 32'h40, 3, 0, 1, 2);
        tbl[10] = mkv(mk(1, 32'h44, 1, 2, 4, 1, 1, 1, 0, 0, 1), 0, 1, 32'h40, 3, 0, 1, 2);
        tbl[11] = mkv(mk(1, 32'h48, 1, 2, 4, 1, 1, 1, 0, 0, 1), 0, 1, 32'h40, 3, 0, 1, 2);
        tbl[12] = mkv(mk(1, 32'h4c, 1, 2, 4, 1, 1, 1, 0, 0, 1), 0, 1, 32'h40, 3, 0, 1, 2);
        tbl[13] = mkv(mk(1, 32'h50, 1, 2, 4, 1, 1, 1, 0, 0, 0), 0, 1, 32'h50, 4, 0, 1, 2);
        tbl[14] = mkv(mk(0, 32'h54, 1, 2, 6, 1, 1, 1, 1, 0, 0), 0, 0, 32'h54, 6, 0, 0, 2);
        tbl[15] = mkv(mk(1, 32'h58, 1, 0, 5, 1, 0, 1, 1, 0, 0), 0, 1, 32'h58, 5, 1, 1, 2);
        tbl[16] = mkv(mk(1, 32'h5c, 5, 0, 6, 1, 0, 1, 0, 0, 1), 1, 1, 32'h58, 5, 1, 1, 2);
        tbl[17] = mkv(mk(1, 32'h5c, 5, 0, 6, 1, 0, 1, 0, 0, 0), 1, 0, 32'h00, 0, 0, 0, 3);
        tbl[18] = mkv(mk(1, 32'h5c, 5, 0, 6, 1, 0, 1, 0, 0, 0), 0, 1, 32'h5c, 6, 0, 1, 3);

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(idle);
        #12;
        chk("reset_ex", 160'(read_ex()), 160'd0);
        chk("reset_stall", 160'(bus.stall), 160'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].s);
            #3;
            chk($sformatf("tbl%0d_stall", i), 160'(bus.stall), 160'(tbl[i].e_stall));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_ex", i),
                160'({bus.EX_valid, bus.EX_pc, bus.EX_rdAddr, bus.EX_memRead, bus.EX_reg_W_En}),
                160'({tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_rd, tbl[i].e_mr, tbl[i].e_we}));
`ifdef ID_EX_BUBBLE_COUNT_EN
            chk($sformatf("tbl%0d_bc", i), 160'(bc_w), 160'(tbl[i].e_bc));
`endif
        end

        // Asynchronous reset mid-cycle while EX holds a valid instruction.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ex", 160'(read_ex()), 160'd0);
        chk("async_rst_stall", 160'(bus.stall), 160'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk("async_rst_bc", 160'(bc_w), 160'd0);
`endif
        apply(idle);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        mex = '0;
        mbc = 32'd0;

        for (int n = 0; n < 400; n++) begin
            rs = rand_stim();
            apply(rs);
            #3;
            m_stall = model_hazard(mex, rs) && !rs.flush;
            chk("rand_stall", 160'(bus.stall), 160'(m_stall));
            @(posedge clk);
            mex = model_next(mex, rs, bub);
            if (bub) mbc = mbc + 32'd1;
            #1;
            chk("rand_ex", 160'(read_ex()), 160'(mex));
`ifdef ID_EX_BUBBLE_COUNT_EN
            chk("rand_bc", 160'(bc_w), 160'(mbc));
`endif
        end

`ifdef ID_EX_BUBBLE_COUNT_EN
        force dut.r_bubble_count = 32'hFFFF_FFFF;
        #1 release dut.r_bubble_count;
        apply(mk(1, 32'h80, 1, 2, 3, 1, 1, 1, 0, 1, 0));
        @(posedge clk); #1;
        chk("bc_wrap", 160'(bc_w), 160'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs ID_valid (1), ID_pc (32), ID_rs1Data (32), ID_rs2Data (32), ID_imm (32): the decoded instruction and its operands.
REQ-004 SHALL have inputs ID_rs1Addr, ID_rs2Addr, ID_rdAddr (5 each), ID_usesRs1, ID_usesRs2 (1 each): source/destination register fields and their use flags.
REQ-005 SHALL have control inputs ID_reg_W_En (1), ID_memRead (1), ID_memWrite (1), ID_aluOp (4), ID_aluSrc (1), ID_wbSel (2), ID_branch (1), ID_jump (1).
REQ-006 SHALL have inputs flush (1), the branch/jump redirect kill from EX, and hold (1), the global pipeline freeze.
REQ-007 SHALL have registered outputs EX_valid, EX_pc, EX_rs1Data, EX_rs2Data, EX_imm, EX_rs1Addr, EX_rs2Addr, EX_rdAddr, EX_reg_W_En, EX_memRead, EX_memWrite, EX_aluOp, EX_aluSrc, EX_wbSel, EX_branch, EX_jump, with the same widths as their ID_ counterparts.
REQ-008 SHALL have combinational output stall (1): load-use hazard, hold PC and IF/ID.

Function
REQ-009 hazard = EX_valid & EX_memRead & (EX_rdAddr != 0) & ID_valid & ((ID_usesRs1 & ID_rs1Addr == EX_rdAddr) | (ID_usesRs2 & ID_rs2Addr == EX_rdAddr)).
REQ-010 stall SHALL be hazard & ~flush; stall SHALL be 0 whenever flush = 1.
REQ-011 Per-edge priority: flush > hold > hazard > normal load.
REQ-012 flush = 1: next edge SHALL load a bubble (EX_valid, EX_reg_W_En, EX_memRead, EX_memWrite, EX_branch, EX_jump = 0; other fields don't-care but SHALL be 0).
REQ-013 hold = 1 and flush = 0: all EX_ registers SHALL retain their value; stall SHALL still reflect the hazard.
REQ-014 hazard = 1, hold = 0, flush = 0: next edge SHALL load a bubble per REQ-012; the ID instruction is re-presented next cycle by upstream.
REQ-015 Otherwise all EX_ outputs SHALL take their ID_ inputs on the next edge (latency 1 cycle).
REQ-016 ID_valid = 0 SHALL load with EX_valid = 0 and all write/memory/branch controls forced to 0.
REQ-017 x0 as destination: EX_reg_W_En SHALL be forced to 0 when ID_rdAddr = 0.
REQ-018 Load-use bubble SHALL be exactly one cycle: after the bubble, EX_memRead = 0 so hazard deasserts and the dependent instruction loads.

Reset
REQ-019 rst_n low SHALL immediately clear every EX_ output to 0, independent of clk.
REQ-020 stall SHALL read 0 during reset, as EX_valid = 0.
REQ-021 Deassertion SHALL take effect at the first rising clk edge with rst_n high; no synchronous reset path.

Configuration
REQ-022 Macro ID_EX_BUBBLE_COUNT_EN SHALL control a bubble performance counter.
REQ-023 Defined: the block SHALL add output bubble_count (32). It SHALL increment by 1 on every edge that loads a bubble due to flush or hazard. It SHALL hold when hold = 1 and flush = 0. It SHALL wrap 0xFFFFFFFF -> 0. It SHALL reset to 0 asynchronously.
REQ-024 Undefined: no bubble_count port or counter logic; all other behaviour identical.

Verification
REQ-025 Reset: rst_n = 0 mid-cycle with EX_valid = 1 -> all EX_ outputs 0 before the next clk edge; stall = 0.
REQ-026 Load-use: EX holds lw x5 (EX_memRead = 1, EX_rdAddr = 5), ID holds add x6,x5,x7 (usesRs1) -> stall = 1 for 1 cycle, bubble loaded, add in EX one cycle later, bubble_count = 1.
REQ-027 No false hazard: EX lw x0, or ID_usesRs2 = 0 with ID_rs2Addr = EX_rdAddr = 5 -> stall = 0, normal load.
REQ-028 Flush with hazard: flush = 1 and hazard conditions true on the same cycle -> stall = 0, bubble loaded, bubble_count +1.
REQ-029 Hold: hold = 1 for 3 cycles with ID_pc changing -> EX_pc stays 0x00000040 throughout and loads the new ID_pc on the first edge after hold drops.
REQ-030 Counter wrap (macro defined): preload 0xFFFFFFFF via 2^32-1 bubbles or force, then one flush -> bubble_count = 0x00000000.
